// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between NREQ write requesters, the FIFO write port and the arbiter
// that shares it. The arbiter side uses the master modport.
interface fifo_wr_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 4,
  parameter int BURST  = 2
);
  localparam int IDW = $clog2(NREQ);
  localparam int BCW = $clog2(BURST + 1);

  // Handshake: req[i] is a level held with stable req_data slice i until ack[i];
  // ack[i] high in a cycle means that slice is written to the FIFO at the next
  // rising edge. write_en is suppressed whenever full or rd_active is high.
  logic [NREQ-1:0]        req;
  logic [NREQ*DWIDTH-1:0] req_data;
  logic                   full;
  logic                   rd_active;
  logic                   write_en;
  logic [DWIDTH-1:0]      data_in;
  logic [NREQ-1:0]        ack;
  logic [IDW-1:0]         grant_id;
  logic                   busy;
  logic                   dbg_state;
  logic [BCW-1:0]         dbg_burst_cnt;
  logic [IDW-1:0]         dbg_last;

  modport master (
    input  req, req_data, full, rd_active,
    output write_en, data_in, ack, grant_id, busy,
    output dbg_state, dbg_burst_cnt, dbg_last
  );

  modport slave (
    output req, req_data, full, rd_active,
    input  write_en, data_in, ack, grant_id, busy,
    input  dbg_state, dbg_burst_cnt, dbg_last
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ requesters,
// with a BURST-write cap per grant tenure and read-collision suppression.
module fifo_wr_arbiter #(
  parameter int NREQ   = 4,
  parameter int DWIDTH = 4,
  parameter int BURST  = 2,
  localparam int IDW   = $clog2(NREQ),
  localparam int BCW   = $clog2(BURST + 1)
) (
  input logic               clk,
  input logic               rst,
  fifo_wr_arbiter_if.master bus
);

  if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
    $error("fifo_wr_arbiter: NREQ must be in 2..16");
  end
  if (BURST < 1) begin : g_bad_burst
    $error("fifo_wr_arbiter: BURST must be >= 1");
  end

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t         state;
  logic [IDW-1:0] owner;
  logic [IDW-1:0] last;
  logic [BCW-1:0] burst_cnt;

  logic [DWIDTH-1:0] req_words [NREQ];
  logic [IDW-1:0]    next_owner;
  logic [IDW:0]      probe;
  logic              found;
  logic              req_own;
  logic              wr;
  logic              burst_done;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_words[i] = bus.req_data[i*DWIDTH +: DWIDTH];
    end
  end

  // Search last+1, last+2, ... wrapping at NREQ; one extra bit holds the sum
  // before the wrap so non-power-of-2 NREQ folds back correctly.
  always_comb begin
    next_owner = last;
    found      = 1'b0;
    probe      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      probe = {1'b0, last} + (IDW+1)'(k);
      if (probe >= (IDW+1)'(NREQ)) begin
        probe = probe - (IDW+1)'(NREQ);
      end
      if (!found && bus.req[probe[IDW-1:0]]) begin
        next_owner = probe[IDW-1:0];
        found      = 1'b1;
      end
    end
  end

  assign req_own    = bus.req[owner];
  assign wr         = (state == ACTIVE) && req_own && !bus.full && !bus.rd_active;
  assign burst_done = (burst_cnt == BCW'(BURST - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      owner     <= '0;
      last      <= IDW'(NREQ - 1);
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            owner     <= next_owner;
            burst_cnt <= '0;
            state     <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (!req_own) begin
            last      <= owner;
            burst_cnt <= '0;
            state     <= IDLE;
          end else if (wr) begin
            if (burst_done) begin
              last      <= owner;
              burst_cnt <= '0;
              state     <= IDLE;
            end else begin
              burst_cnt <= burst_cnt + BCW'(1);
            end
          end
          // Stalled by full or a read: keep tenure and count unchanged.
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.write_en      = wr;
  assign bus.ack           = wr ? (NREQ'(1) << owner) : '0;
  assign bus.data_in       = (state == ACTIVE) ? req_words[owner] : '0;
  assign bus.grant_id      = owner;
  assign bus.busy          = (state == ACTIVE);
  assign bus.dbg_state     = state;
  assign bus.dbg_burst_cnt = burst_cnt;
  assign bus.dbg_last      = last;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: requester queues drive the ports,
// a scoreboard of {grant_id,data} checks each write, a FIFO model checks readback.
module tb_fifo_wr_arbiter;
  localparam int NREQ   = 4;
  localparam int DWIDTH = 4;
  localparam int BURST  = 2;
  localparam int IDW    = 2;
  localparam int W      = IDW + DWIDTH;
  localparam int FDEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NREQ(NREQ), .DWIDTH(DWIDTH), .BURST(BURST)) bus ();

  fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DWIDTH), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  logic [DWIDTH-1:0] src_q [NREQ][$];
  logic [DWIDTH-1:0] rd_exp [NREQ][$];
  logic [DWIDTH-1:0] mfifo [$];
  logic [W-1:0]      exp_q [$];
  logic [NREQ-1:0]   ack_seen;
  logic              full_nxt;
  logic              rd_nxt;
  bit                fifo_mode;
  int                rd_count;
  int                n_tests = 0;
  int                n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NREQ; i++) begin
      bus.req[i] = (src_q[i].size() > 0);
      bus.req_data[i*DWIDTH +: DWIDTH] = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
  endtask

  task automatic sample();
    logic [NREQ-1:0]   exp_ack;
    logic [W-1:0]      e;
    logic [DWIDTH-1:0] v;
    int                r;
    ack_seen = bus.ack;
    exp_ack  = bus.write_en ? (NREQ'(1) << bus.grant_id) : '0;
    check("wr_blocked", 32'(bus.write_en & (bus.full | bus.rd_active)), 32'd0);
    check("ack_vs_wr", 32'(bus.ack), 32'(exp_ack));
    if (fifo_mode) begin
      if (bus.rd_active) begin
        v = mfifo.pop_front();
        r = int'(v[3:2]);
        rd_count++;
        if (rd_exp[r].size() == 0) check("rd_extra", 32'(v), 32'hFFFF);
        else check("rd_order", 32'(v), 32'(rd_exp[r].pop_front()));
      end
      if (bus.write_en) mfifo.push_back(bus.data_in);
    end else if (bus.write_en) begin
      if (exp_q.size() == 0) begin
        check("extra_write", 32'(bus.write_en), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_id", 32'(bus.grant_id), 32'(e[W-1:DWIDTH]));
        check("wr_data", 32'(bus.data_in), 32'(e[DWIDTH-1:0]));
      end
    end
  endtask

  task automatic cycle();
    bit sent;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        if (ack_seen[i] && src_q[i].size() > 0) src_q[i].delete(0);
      end
    end
    ack_seen = '0;
    drive_reqs();
    if (fifo_mode) begin
      sent = 1'b1;
      for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) sent = 1'b0;
      bus.full      = (mfifo.size() >= FDEPTH);
      bus.rd_active = (mfifo.size() > 0) && (sent || $urandom_range(0, 2) == 0);
    end else begin
      bus.full      = full_nxt;
      bus.rd_active = rd_nxt;
    end
    @(negedge clk);
    if (rst) sample();
  endtask

  task automatic clear_all();
    for (int i = 0; i < NREQ; i++) begin
      src_q[i].delete();
      rd_exp[i].delete();
    end
    exp_q.delete();
    mfifo.delete();
    ack_seen  = '0;
    full_nxt  = 1'b0;
    rd_nxt    = 1'b0;
    fifo_mode = 1'b0;
    rd_count  = 0;
    bus.full      = 1'b0;
    bus.rd_active = 1'b0;
    drive_reqs();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic run_until_empty(input int budget, output int n);
    n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic push_exp(input int id, input int d);
    exp_q.push_back({IDW'(id), DWIDTH'(d)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic t1_we [5];
    rst = 1'b0;
    clear_all();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_write_en", 32'(bus.write_en), 32'd0);
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_data_in", 32'(bus.data_in), 32'd0);
    check("rst_grant_id", 32'(bus.grant_id), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_last", 32'(bus.dbg_last), 32'(NREQ - 1));
    check("rst_burst_cnt", 32'(bus.dbg_burst_cnt), 32'd0);
    #1 rst = 1'b1;

    // 1: single requester, burst of two then one idle bubble and regrant
    src_q[0].push_back(4'hA); src_q[0].push_back(4'hB); src_q[0].push_back(4'hC);
    push_exp(0, 'hA); push_exp(0, 'hB); push_exp(0, 'hC);
    t1_we = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int c = 0; c < 5; c++) begin
      cycle();
      check($sformatf("t1_we_c%0d", c + 1), 32'(bus.write_en), 32'(t1_we[c]));
      check($sformatf("t1_busy_c%0d", c + 1), 32'(bus.busy), 32'(t1_we[c]));
    end
    check("t1_drain", 32'(exp_q.size()), 32'd0);

    // 2: all four requesting, strict rotation with one bubble per handoff
    do_reset();
    for (int i = 0; i < NREQ; i++) repeat (4) src_q[i].push_back(DWIDTH'(i + 1));
    for (int k = 0; k < 10; k++) push_exp((k / 2) % NREQ, ((k / 2) % NREQ) + 1);
    run_until_empty(40, n);
    check("t2_cycles", 32'(n), 32'd15);

    // 3: full stall while owner 2 holds the grant
    do_reset();
    src_q[2].push_back(4'h5); src_q[2].push_back(4'h6);
    push_exp(2, 5); push_exp(2, 6);
    cycle();
    check("t3_idle_busy", 32'(bus.busy), 32'd0);
    full_nxt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle();
      check("t3_stall_we", 32'(bus.write_en), 32'd0);
      check("t3_stall_ack", 32'(bus.ack), 32'd0);
      check("t3_stall_busy", 32'(bus.busy), 32'd1);
      check("t3_stall_gid", 32'(bus.grant_id), 32'd2);
    end
    full_nxt = 1'b0;
    cycle();
    check("t3_release_we", 32'(bus.write_en), 32'd1);
    full_nxt = 1'b1;
    repeat (2) cycle();
    check("t3_held_cnt", 32'(bus.dbg_burst_cnt), 32'd1);
    check("t3_held_we", 32'(bus.write_en), 32'd0);
    full_nxt = 1'b0;
    cycle();
    check("t3_second_we", 32'(bus.write_en), 32'd1);
    cycle();
    check("t3_end_busy", 32'(bus.busy), 32'd0);
    check("t3_drain", 32'(exp_q.size()), 32'd0);

    // 4a: read collision delays the write by one cycle
    do_reset();
    src_q[1].push_back(4'h7); src_q[1].push_back(4'h8);
    push_exp(1, 7); push_exp(1, 8);
    cycle();
    rd_nxt = 1'b1;
    cycle();
    check("t4_rd_we", 32'(bus.write_en), 32'd0);
    check("t4_rd_busy", 32'(bus.busy), 32'd1);
    rd_nxt = 1'b0;
    cycle();
    check("t4_next_we", 32'(bus.write_en), 32'd1);
    run_until_empty(10, n);

    // 4b: 16 values through a FIFO model with random reads and full
    do_reset();
    fifo_mode = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < 4; k++) begin
        src_q[i].push_back(DWIDTH'(i * 4 + k));
        rd_exp[i].push_back(DWIDTH'(i * 4 + k));
      end
    end
    n = 0;
    while (rd_count < 16 && n < 600) begin
      cycle();
      n++;
    end
    check("t4_rd_count", 32'(rd_count), 32'd16);
    check("t4_fifo_empty", 32'(mfifo.size()), 32'd0);

    // 5: early release by owner 1 hands the port to requester 3
    do_reset();
    src_q[1].push_back(4'h9);
    src_q[3].push_back(4'hC);
    push_exp(1, 9); push_exp(3, 'hC);
    cycle();
    cycle();
    check("t5_first_gid", 32'(bus.grant_id), 32'd1);
    cycle();
    check("t5_release_we", 32'(bus.write_en), 32'd0);
    check("t5_release_busy", 32'(bus.busy), 32'd1);
    cycle();
    check("t5_idle_busy", 32'(bus.busy), 32'd0);
    check("t5_last", 32'(bus.dbg_last), 32'd1);
    run_until_empty(10, n);

    // 6: asynchronous reset in the middle of an active write
    do_reset();
    src_q[0].push_back(4'h1); src_q[0].push_back(4'h2);
    push_exp(0, 1); push_exp(0, 2);
    cycle();
    cycle();
    check("t6_pre_we", 32'(bus.write_en), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("t6_rst_we", 32'(bus.write_en), 32'd0);
    check("t6_rst_ack", 32'(bus.ack), 32'd0);
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    check("t6_rst_data", 32'(bus.data_in), 32'd0);
    clear_all();
    src_q[1].push_back(4'h3);
    src_q[3].push_back(4'h4);
    drive_reqs();
    push_exp(1, 3); push_exp(3, 4);
    @(posedge clk);
    #1 rst = 1'b1;
    check("t6_last_after_rst", 32'(bus.dbg_last), 32'(NREQ - 1));
    run_until_empty(20, n);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
